ps2_key_event_queue: RTL and testbench

// Parametrised successor to the single-keycode PS/2 keyboard receiver. It deserialises
// PS/2 frames and decodes E0/F0 prefixes into make/break events, pushing them into a

---
 rtl/ps2_key_event_queue.sv | 189 ++++++++++++++++++
 tb/tb_ps2_key_event_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_queue.sv
// rtl/ps2_key_event_queue.sv - PS/2 receiver with make/break decoder, event FIFO and held-key bitmap
module ps2_key_event_queue #(
    parameter int                     FIFO_DEPTH      = 8,
    parameter int                     NUM_TRACK       = 4,
    parameter logic [NUM_TRACK*8-1:0] TRACK_CODES     = {NUM_TRACK{8'h00}},
    parameter int                     TIMEOUT_CYC     = 50000,
    parameter bit                     SUPPRESS_REPEAT = 1'b1
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          psClk,
    input  logic                          psData,
    input  logic                          rd_en,
    input  logic                          clr_ovf,
    output logic                          evt_valid,
    output logic [15:0]                   evt_code,
    output logic                          evt_press,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic [NUM_TRACK-1:0]          held
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic          ps_clk_s1, ps_clk_s2, ps_clk_d;
    logic          ps_data_s1, ps_data_s2;
    logic          fall;
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] to_cnt;
    logic          byte_done;

    logic                 ext_q, brk_q;
    logic                 is_e0, is_f0, is_drop, is_evt, suppress, wr;
    logic [NUM_TRACK-1:0] match;
    logic [16:0]          wr_data;

    logic [16:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, push, drop;

    // Two-flop synchronisers; psClk history resets high so reset release never looks like a fall
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ps_clk_s1  <= 1'b1;
            ps_clk_s2  <= 1'b1;
            ps_clk_d   <= 1'b1;
            ps_data_s1 <= 1'b1;
            ps_data_s2 <= 1'b1;
        end else begin
            ps_clk_s1  <= psClk;
            ps_clk_s2  <= ps_clk_s1;
            ps_clk_d   <= ps_clk_s2;
            ps_data_s1 <= psData;
            ps_data_s2 <= ps_data_s1;
        end
    end

    assign fall = ps_clk_d & ~ps_clk_s2;

    // Frame FSM stepped by psClk falls, with an inactivity timeout that silently aborts a frame
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            to_cnt     <= '0;
            byte_done  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            byte_done  <= 1'b0;
            parity_err <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                case (state)
                    S_IDLE: begin
                        if (!ps_data_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        shift_q <= {ps_data_s2, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_q <= ps_data_s2;
                        state <= S_STOP;
                    end
                    default: begin
                        if (ps_data_s2 && (^{par_q, shift_q})) byte_done  <= 1'b1;
                        else                                   parity_err <= 1'b1;
                        state <= S_IDLE;
                    end
                endcase
            end else if (state != S_IDLE) begin
                if (to_cnt == TO_LAST) begin
                    state  <= S_IDLE;
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // Byte classification and tracked-key match; shift_q holds the byte while byte_done is high
    always_comb begin
        is_e0   = (shift_q == 8'hE0);
        is_f0   = (shift_q == 8'hF0);
        is_drop = (shift_q == 8'hFA) || (shift_q == 8'hAA) || (shift_q == 8'hEE) ||
                  (shift_q == 8'hFE) || (shift_q == 8'h00) || (shift_q == 8'hFF);
        is_evt  = byte_done && !is_e0 && !is_f0 && !is_drop;
        match   = '0;
        for (int i = 0; i < NUM_TRACK; i++) begin
            match[i] = !ext_q && (shift_q == TRACK_CODES[8*i +: 8]);
        end
        suppress = SUPPRESS_REPEAT && !brk_q && (|(match & held));
        wr       = is_evt && !suppress;
        wr_data  = {(ext_q ? 8'hE0 : 8'h00), shift_q, ~brk_q};
    end

    // Prefix flags and held-key bitmap
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            held  <= '0;
        end else if (byte_done) begin
            if (is_e0) begin
                ext_q <= 1'b1;
            end else if (is_f0) begin
                brk_q <= 1'b1;
            end else if (!is_drop) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
                if (brk_q) held <= held & ~match;
                else       held <= held | match;
            end
        end
    end

    assign full = (fifo_count == DEPTH_C);
    assign pop  = rd_en && (fifo_count != '0);
    assign push = wr && (!full || pop);
    assign drop = wr && full && !pop;

    // Event storage, written only when the entry will be kept
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Queue pointers, occupancy and sticky overflow (a drop beats clr_ovf)
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_count <= fifo_count + (AW+1)'(1);
            else if (pop && !push) fifo_count <= fifo_count - (AW+1)'(1);
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign evt_valid = (fifo_count != '0);
    assign evt_code  = evt_valid ? mem[rd_ptr][16:1] : 16'h0000;
    assign evt_press = evt_valid ? mem[rd_ptr][0]    : 1'b0;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// tb/tb_ps2_key_event_queue.sv - directed self-checking bench for ps2_key_event_queue
module tb_ps2_key_event_queue;

    logic        Clk = 1'b0;
    logic        Reset_n, psClk, psData, rd_en, clr_ovf;
    logic        evt_valid, evt_press, overflow, parity_err;
    logic [15:0] evt_code;
    logic [3:0]  fifo_count;
    logic [3:0]  held;

    int checks   = 0;
    int failures = 0;
    int perr_cnt = 0;
    int perr_base;

    logic [7:0] codes [9] = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

    ps2_key_event_queue #(
        .FIFO_DEPTH     (8),
        .NUM_TRACK      (4),
        .TRACK_CODES    (32'h0000_1C1D),
        .TIMEOUT_CYC    (50000),
        .SUPPRESS_REPEAT(1'b1)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .psClk     (psClk),
        .psData    (psData),
        .rd_en     (rd_en),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_press (evt_press),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .parity_err(parity_err),
        .held      (held)
    );

    always #5 Clk = ~Clk;

    // Count parity_err pulses as observed on the output
    always @(posedge Clk) if (parity_err) perr_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge Clk) psData = b;
        repeat (4) @(negedge Clk);
        psClk = 1'b0;
        repeat (4) @(negedge Clk);
        psClk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        repeat (10) @(negedge Clk);
    endtask

    // Same as send_frame but pulses rd_en for exactly the cycle in which the FIFO write lands
    task automatic send_frame_pop_at_write(input logic [7:0] b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b);
        @(negedge Clk) psData = 1'b1;
        repeat (4) @(negedge Clk);
        psClk = 1'b0;
        repeat (3) @(negedge Clk);
        rd_en = 1'b1;
        @(negedge Clk) rd_en = 1'b0;
        repeat (4) @(negedge Clk);
        psClk = 1'b1;
        repeat (10) @(negedge Clk);
    endtask

    task automatic pop();
        @(negedge Clk) rd_en = 1'b1;
        @(negedge Clk) rd_en = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; psClk = 1'b1; psData = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0;
        repeat (5) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);

        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_code", 32'(evt_code), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_held", 32'(held), 32'd0);

        // T1: tracked make then break
        send_frame(8'h1D, 1'b0);
        check("t1_valid", 32'(evt_valid), 32'd1);
        check("t1_code", 32'(evt_code), 32'h001D);
        check("t1_press", 32'(evt_press), 32'd1);
        check("t1_held", 32'(held), 32'd1);
        check("t1_count", 32'(fifo_count), 32'd1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1D, 1'b0);
        check("t1_count2", 32'(fifo_count), 32'd2);
        check("t1_held2", 32'(held), 32'd0);
        pop();
        check("t1_code2", 32'(evt_code), 32'h001D);
        check("t1_press2", 32'(evt_press), 32'd0);
        pop();
        check("t1_empty", 32'(evt_valid), 32'd0);

        // T2: extended break, then an ACK byte that must not enqueue
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("t2_count", 32'(fifo_count), 32'd1);
        check("t2_code", 32'(evt_code), 32'hE075);
        check("t2_press", 32'(evt_press), 32'd0);
        send_frame(8'hFA, 1'b0);
        check("t2_fa_count", 32'(fifo_count), 32'd1);
        pop();

        // T3: bad parity
        perr_base = perr_cnt;
        send_frame(8'h1D, 1'b1);
        check("t3_perr", 32'(perr_cnt - perr_base), 32'd1);
        check("t3_count", 32'(fifo_count), 32'd0);
        check("t3_held", 32'(held), 32'd0);

        // T4: overflow on the ninth make, contents intact
        for (int i = 0; i < 9; i++) send_frame(codes[i], 1'b0);
        check("t4_count", 32'(fifo_count), 32'd8);
        check("t4_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_pop%0d", i), 32'(evt_code), {16'h0, 8'h00, codes[i]});
            pop();
        end
        check("t4_drained", 32'(fifo_count), 32'd0);
        @(negedge Clk) clr_ovf = 1'b1;
        @(negedge Clk) clr_ovf = 1'b0;
        check("t4_clr_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) send_frame(codes[i], 1'b0);
        check("t4_refill", 32'(fifo_count), 32'd8);
        send_frame_pop_at_write(8'h46);
        check("t4_full_rw_count", 32'(fifo_count), 32'd8);
        check("t4_full_rw_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("t4_rw_pop%0d", i), 32'(evt_code), {16'h0, 8'h00, codes[i]});
            pop();
        end
        check("t4_rw_last", 32'(evt_code), 32'h0046);
        pop();
        check("t4_rw_empty", 32'(fifo_count), 32'd0);

        // T5: partial frame aborted by timeout, then a clean frame
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (60000) @(negedge Clk);
        send_frame(8'h29, 1'b0);
        check("t5_count", 32'(fifo_count), 32'd1);
        check("t5_code", 32'(evt_code), 32'h0029);
        pop();

        // T5b: reset mid-frame clears everything
        send_frame(8'h1D, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge Clk) Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (20) @(negedge Clk);
        check("t5r_valid", 32'(evt_valid), 32'd0);
        check("t5r_count", 32'(fifo_count), 32'd0);
        check("t5r_code", 32'(evt_code), 32'd0);
        check("t5r_held", 32'(held), 32'd0);
        check("t5r_ovf", 32'(overflow), 32'd0);

        // T6: typematic repeats of a held tracked key are suppressed
        send_frame(8'h1D, 1'b0);
        send_frame(8'h1D, 1'b0);
        send_frame(8'h1D, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1D, 1'b0);
        check("t6_count", 32'(fifo_count), 32'd2);
        check("t6_press1", 32'(evt_press), 32'd1);
        pop();
        check("t6_code2", 32'(evt_code), 32'h001D);
        check("t6_press2", 32'(evt_press), 32'd0);
        check("t6_held", 32'(held), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
